// File: rtl/wbr_seq_ctrl.sv
// Sequencer for one wrapper boundary register: shift a pattern in, apply/capture,
// shift the response out and compare it against the expected value.
module wbr_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   // "expect" is a reserved word in SystemVerilog, hence "expected"
   input  logic [WIDTH-1:0] expected,
   input  logic             WPSO,
   output logic             WPSI,
   output logic             wse_inputs,
   output logic             hold_inputs,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             pass
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      APPLY,
      SHIFT_OUT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic             samp_q, samp_d;
   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic [WIDTH-1:0] expect_q, expect_d;
   logic [WIDTH-1:0] result_sr_q, result_sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             wpsi_q, wpsi_d;
   logic             wse_q, wse_d;
   logic             hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   // Pins are registered from the current state, so they trail the state
   // register by one cycle; WPSO sampling is delayed to the same phase.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      scnt_d      = cnt_q;
      samp_d      = 1'b0;
      pattern_d   = pattern_q;
      expect_d    = expect_q;
      result_d    = result_q;
      pass_d      = pass_q;
      wpsi_d      = 1'b0;
      wse_d       = 1'b0;
      hold_d      = 1'b1;
      done_d      = 1'b0;

      result_sr_d = result_sr_q;
      if (samp_q) begin
         result_sr_d[scnt_q] = WPSO;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               pattern_d = pattern;
               expect_d  = expected;
               cnt_d     = '0;
               state_d   = SHIFT_IN;
            end
         end
         SHIFT_IN: begin
            wpsi_d = pattern_q[cnt_q];
            wse_d  = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = APPLY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         APPLY: begin
            hold_d  = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT_OUT;
         end
         SHIFT_OUT: begin
            wse_d  = 1'b1;
            samp_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // The last response bit arrives on this same edge via result_sr_d
            done_d   = 1'b1;
            result_d = result_sr_d;
            pass_d   = (result_sr_d == expect_q);
            cnt_d    = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         state_d   = IDLE;
         cnt_d     = '0;
         samp_d    = 1'b0;
         pattern_d = pattern_q;
         expect_d  = expect_q;
         result_d  = result_q;
         pass_d    = pass_q;
         wpsi_d    = 1'b0;
         wse_d     = 1'b0;
         hold_d    = 1'b1;
         done_d    = 1'b0;
      end

      // Stays high through the cycle in which done is shown
      busy_d = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         scnt_q      <= '0;
         samp_q      <= 1'b0;
         pattern_q   <= '0;
         expect_q    <= '0;
         result_sr_q <= '0;
         result_q    <= '0;
         pass_q      <= 1'b0;
         wpsi_q      <= 1'b0;
         wse_q       <= 1'b0;
         hold_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         scnt_q      <= scnt_d;
         samp_q      <= samp_d;
         pattern_q   <= pattern_d;
         expect_q    <= expect_d;
         result_sr_q <= result_sr_d;
         result_q    <= result_d;
         pass_q      <= pass_d;
         wpsi_q      <= wpsi_d;
         wse_q       <= wse_d;
         hold_q      <= hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign WPSI        = wpsi_q;
   assign wse_inputs  = wse_q;
   assign hold_inputs = hold_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign pass        = pass_q;

endmodule
